mlp_seq_classifier: RTL and testbench
=====================================

MLP_SEQ_CLASSIFIER -- requirements
Module: mlp_seq_classifier

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- N_IN, 6, number of input features.
- IN_W, 4, unsigned feature width.
- N_HID, 3, hidden neurons.
- N_OUT, 3, output classes.
- WGT_W, 8, signed weight width.
- ACC0_W, 12, signed hidden accumulator width.
- ACC1_W, 19, signed output accumulator width.
- W0, {-7,12,3,-12,-15,35 | 0,1,3,1,-1,-3 | 5,4,13,3,2,81}, hidden weights; neuron j, input i at W0[(j*N_IN+i)*WGT_W +: WGT_W].
- B0, {204,-127,-251}, hidden biases; neuron j at B0[j*ACC0_W +: ACC0_W].
- W1, {36,1,-63 | -30,8,19 | -6,0,47}, output weights; class k, hidden j at W1[(k*N_HID+j)*WGT_W +: WGT_W].
- B1, {-3568,4334,-2100}, output biases; class k at B1[k*ACC1_W +: ACC1_W].
REQ-002 CLS_W SHALL be derived as max(1, ceil(log2(N_OUT))).
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on the rising edge.
- rst, in, 1, synchronous, active-high reset.
- in_valid, in, 1, input vector present.
- in_ready, out, 1, block can accept an input vector.
- inp, in, N_IN*IN_W, feature i at inp[i*IN_W +: IN_W], unsigned.
- out_valid, out, 1, result present.
- out_ready, in, 1, consumer accepts the result.
- out, out, CLS_W, winning class index.
- out_score, out, ACC1_W-1, ReLU value of the winning class.
- busy, out, 1, high in states L0 and L1.

Function
REQ-004 The FSM SHALL have states IDLE, L0, L1 and DONE, with in_ready = (state==IDLE).
REQ-005 On in_valid && in_ready, the block SHALL register inp, clear the counters and enter L0; inp SHALL be ignored at all other times.
REQ-006 L0 SHALL perform one MAC per cycle over neurons j=0..N_HID-1 and inputs i=0..N_IN-1, occupying N_HID*N_IN cycles.
REQ-007 On i=0 the hidden accumulator SHALL load B0[j] + x0*W0[j][0]; on each later i it SHALL add xi*W0[j][i].
REQ-008 On i=N_IN-1, h[j] SHALL be stored as 0 if the final sum is negative, else as the sum's low ACC0_W-1 bits.
REQ-009 L1 SHALL proceed in the same way over classes k and hidden j, using B1 and W1 and the unsigned h[j] zero-extended, occupying N_OUT*N_HID cycles; the ReLU result is ACC1_W-1 bits.
REQ-010 Argmax SHALL be computed incrementally as each class completes.
- Class 0 loads best_val and best_idx unconditionally.
- Class k>0 replaces the best only if its value is strictly greater, so ties resolve to the lowest index.
REQ-011 All sums SHALL wrap in two's complement at the accumulator width; there is no saturation.
REQ-012 After the last L1 MAC the block SHALL enter DONE with out_valid=1.
- out_valid rises exactly N_HID*N_IN + N_OUT*N_HID cycles after the accepting edge (27 at defaults).
REQ-013 In DONE, out and out_score SHALL be held stable while out_ready=0.
REQ-014 On out_valid && out_ready the block SHALL return to IDLE and drop out_valid on the next cycle; no new input is accepted in that same cycle.
REQ-015 out and out_score SHALL retain the last result until the next DONE.
REQ-016 Changes on in_valid or inp while busy SHALL have no effect on the result.

Reset
REQ-017 When rst=1 at a clock edge, the block SHALL go to IDLE with out_valid=0, out=0, out_score=0, busy=0, all accumulators, h[] and counters at 0, and in_ready=1 from the first cycle after rst deasserts.
REQ-018 rst SHALL take priority over every handshake, and a reset during L0, L1 or DONE SHALL abort the computation with no output produced.

Verification
REQ-019 Defaults, inp=24'h000000 accepted -> out_valid exactly 27 cycles later, out=0, out_score=3776.
REQ-020 Defaults, inp=24'hFFFFFF -> h={444,0,1369}, out=2, out_score=59579.
REQ-021 W1 all zero, B1 all zero -> out=0, out_score=0 (tie resolved to lowest index).
REQ-022 Back-pressure: out_ready held 0 for 10 cycles after out_valid, in_valid=1 with changing inp -> out and out_score stable, in_ready=0; after out_ready pulse, in_ready=1 on the following cycle.
REQ-023 rst pulsed 10 cycles into L0 -> out_valid never asserts for that vector; a following all-zero vector gives out=0, out_score=3776 after 27 cycles.
REQ-024 Back-to-back vectors with out_ready tied 1 -> each result correct, with one IDLE cycle between consecutive DONE and accept.

Source files
------------

// File: rtl/mlp_seq_classifier.sv
// Sequential two-layer MLP classifier: one MAC per cycle through the hidden layer,
// then the output layer, with a running argmax over the ReLU'd class scores.
module mlp_seq_classifier #(
  parameter int N_IN   = 6,
  parameter int IN_W   = 4,
  parameter int N_HID  = 3,
  parameter int N_OUT  = 3,
  parameter int WGT_W  = 8,
  parameter int ACC0_W = 12,
  parameter int ACC1_W = 19,
  parameter logic [N_HID*N_IN*WGT_W-1:0] W0 = {
    8'(81), 8'(2),  8'(3),   8'(13),  8'(4), 8'(5),
    8'(-3), 8'(-1), 8'(1),   8'(3),   8'(1), 8'(0),
    8'(35), 8'(-15), 8'(-12), 8'(3),  8'(12), 8'(-7)},
  parameter logic [N_HID*ACC0_W-1:0] B0 = {12'(-251), 12'(-127), 12'(204)},
  parameter logic [N_OUT*N_HID*WGT_W-1:0] W1 = {
    8'(47), 8'(0), 8'(-6),
    8'(19), 8'(8), 8'(-30),
    8'(-63), 8'(1), 8'(36)},
  parameter logic [N_OUT*ACC1_W-1:0] B1 = {19'(-2100), 19'(4334), 19'(-3568)},
  localparam int CLS_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*IN_W-1:0]   inp,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CLS_W-1:0]       out,
  output logic [ACC1_W-2:0]      out_score,
  output logic                   busy
);

  localparam int IW = $clog2(((N_IN > N_HID) ? N_IN : N_HID) + 1);
  localparam int JW = $clog2(((N_HID > N_OUT) ? N_HID : N_OUT) + 1);
  localparam int HW = ACC0_W - 1;

  typedef enum logic [1:0] {IDLE, L0, L1, DONE} state_t;
  state_t state, state_nx;

  logic [IW-1:0]              i_cnt;
  logic [JW-1:0]              j_cnt;
  logic [N_IN*IN_W-1:0]       x_reg;
  logic [N_HID*HW-1:0]        h;
  logic signed [ACC0_W-1:0]   acc0, sum0, b0_sel, p0_ext;
  logic signed [ACC1_W-1:0]   acc1, sum1, b1_sel, p1_ext;
  logic signed [IN_W+WGT_W:0] p0;
  logic signed [HW+WGT_W:0]   p1;
  logic [IN_W-1:0]            x_sel;
  logic [HW-1:0]              h_sel;
  logic signed [WGT_W-1:0]    w0_sel, w1_sel;
  logic [ACC1_W-2:0]          relu1, best_val, best_val_nx;
  logic [CLS_W-1:0]           best_idx, best_idx_nx;
  logic                       last_i0, last_j0, last_i1, last_j1;

  always_comb begin
    last_i0 = (i_cnt == IW'(N_IN - 1));
    last_j0 = (j_cnt == JW'(N_HID - 1));
    last_i1 = (i_cnt == IW'(N_HID - 1));
    last_j1 = (j_cnt == JW'(N_OUT - 1));
  end

  // Hidden layer MAC: unsigned feature times signed weight, wrapping at ACC0_W.
  always_comb begin
    x_sel  = x_reg[i_cnt*IN_W +: IN_W];
    w0_sel = W0[(j_cnt*N_IN + i_cnt)*WGT_W +: WGT_W];
    b0_sel = B0[j_cnt*ACC0_W +: ACC0_W];
    p0     = $signed({1'b0, x_sel}) * w0_sel;
    p0_ext = ACC0_W'(p0);
    sum0   = ((i_cnt == '0) ? b0_sel : acc0) + p0_ext;
  end

  // Output layer MAC on zero-extended hidden activations, wrapping at ACC1_W.
  always_comb begin
    h_sel  = h[i_cnt*HW +: HW];
    w1_sel = W1[(j_cnt*N_HID + i_cnt)*WGT_W +: WGT_W];
    b1_sel = B1[j_cnt*ACC1_W +: ACC1_W];
    p1     = $signed({1'b0, h_sel}) * w1_sel;
    p1_ext = ACC1_W'(p1);
    sum1   = ((i_cnt == '0) ? b1_sel : acc1) + p1_ext;
    relu1  = sum1[ACC1_W-1] ? '0 : sum1[ACC1_W-2:0];
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_val_nx = best_val;
    best_idx_nx = best_idx;
    if (j_cnt == '0 || relu1 > best_val) begin
      best_val_nx = relu1;
      best_idx_nx = CLS_W'(j_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == L0) || (state == L1);
    case (state)
      IDLE: if (in_valid)            state_nx = L0;
      L0:   if (last_i0 && last_j0)  state_nx = L1;
      L1:   if (last_i1 && last_j1)  state_nx = DONE;
      DONE: if (out_ready)           state_nx = IDLE;
      default:                       state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_cnt     <= '0;
      j_cnt     <= '0;
      x_reg     <= '0;
      h         <= '0;
      acc0      <= '0;
      acc1      <= '0;
      best_val  <= '0;
      best_idx  <= '0;
      out       <= '0;
      out_score <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x_reg <= inp;
          i_cnt <= '0;
          j_cnt <= '0;
        end
        L0: begin
          acc0 <= sum0;
          if (last_i0) begin
            h[j_cnt*HW +: HW] <= sum0[ACC0_W-1] ? '0 : sum0[HW-1:0];
            i_cnt <= '0;
            j_cnt <= last_j0 ? '0 : j_cnt + 1'b1;
          end else begin
            i_cnt <= i_cnt + 1'b1;
          end
        end
        L1: begin
          acc1 <= sum1;
          if (last_i1) begin
            best_val <= best_val_nx;
            best_idx <= best_idx_nx;
            i_cnt    <= '0;
            if (last_j1) begin
              j_cnt     <= '0;
              out       <= best_idx_nx;
              out_score <= best_val_nx;
            end else begin
              j_cnt <= j_cnt + 1'b1;
            end
          end else begin
            i_cnt <= i_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_seq_classifier.sv
// Scoreboard bench for mlp_seq_classifier: a reference dot-product model predicts
// each result at accept time; a monitor pops and compares on every output handshake.
module tb_mlp_seq_classifier;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, in_ready, out_valid, busy;
  logic [23:0] inp;
  logic [1:0]  out;
  logic [17:0] out_score;

  logic        z_in_valid, z_in_ready, z_out_valid, z_busy;
  logic [23:0] z_inp;
  logic [1:0]  z_out;
  logic [17:0] z_out_score;

  mlp_seq_classifier dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inp(inp),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_score(out_score),
    .busy(busy));

  mlp_seq_classifier #(.W1('0), .B1('0)) dut_z (
    .clk(clk), .rst(rst), .in_valid(z_in_valid), .in_ready(z_in_ready), .inp(z_inp),
    .out_valid(z_out_valid), .out_ready(1'b1), .out(z_out), .out_score(z_out_score),
    .busy(z_busy));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  int exp_cls_q[$], exp_score_q[$];
  int accept_cyc = 0, last_hs_cyc = 0;
  bit chk_gap = 0, prev_ov = 0;

  localparam int W0_T [3][6] = '{'{-7, 12, 3, -12, -15, 35},
                                 '{0, 1, 3, 1, -1, -3},
                                 '{5, 4, 13, 3, 2, 81}};
  localparam int B0_T [3]    = '{204, -127, -251};
  localparam int W1_T [3][3] = '{'{36, 1, -63}, '{-30, 8, 19}, '{-6, 0, 47}};
  localparam int B1_T [3]    = '{-3568, 4334, -2100};

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model(input logic [23:0] x, output int cls, output int score);
    int s, v;
    int hv [3];
    logic signed [11:0] s12;
    logic signed [18:0] s19;
    for (int j = 0; j < 3; j++) begin
      s = B0_T[j];
      for (int i = 0; i < 6; i++) s += int'(x[i*4 +: 4]) * W0_T[j][i];
      s12 = 12'(s);
      hv[j] = (s12 < 0) ? 0 : int'(s12);
    end
    cls = 0; score = 0;
    for (int k = 0; k < 3; k++) begin
      s = B1_T[k];
      for (int j = 0; j < 3; j++) s += hv[j] * W1_T[k][j];
      s19 = 19'(s);
      v = (s19 < 0) ? 0 : int'(s19);
      if (k == 0 || v > score) begin
        score = v;
        cls = k;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !prev_ov) chk("latency", cyc - accept_cyc, 27);
      if (out_valid && out_ready) begin
        if (exp_cls_q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          chk("cls", int'(out), exp_cls_q.pop_front());
          chk("score", int'(out_score), exp_score_q.pop_front());
        end
        last_hs_cyc <= cyc;
      end
    end
    prev_ov <= out_valid;
  end

  task automatic send(input logic [23:0] x, input bit push);
    int n = 0;
    int c, s;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    inp = x;
    if (push) begin
      model(x, c, s);
      exp_cls_q.push_back(c);
      exp_score_q.push_back(s);
    end
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    in_valid = 1'b0;
    inp = 24'($urandom);
    if (chk_gap) chk("idle_gap", accept_cyc - last_hs_cyc, 2);
  endtask

  task automatic wait_ov(input int maxc);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  initial begin
    logic [23:0] pats [6];
    int ec, es, ov_seen, n;
    pats = '{24'h123456, 24'hF0F0F0, 24'h0F0F0F, 24'h00000F, 24'hF00000, 24'h3C5A96};
    rst = 1'b1; in_valid = 1'b0; inp = '0; out_ready = 1'b1;
    z_in_valid = 1'b0; z_inp = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", int'(out), 0);
    chk("rst_score", int'(out_score), 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);

    // Basic vectors, then back-to-back with out_ready held high
    send(24'h000000, 1);
    @(negedge clk);
    chk("busy_l0", busy, 1);
    chk("in_ready_l0", in_ready, 0);
    chk_gap = 1;
    send(24'hFFFFFF, 1);
    // Noise on in_valid/inp while busy must not disturb the result
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      inp = 24'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    foreach (pats[p]) send(pats[p], 1);
    for (int r = 0; r < 6; r++) send(24'($urandom), 1);

    // Back-pressure: result held while out_ready is low
    n = 0;
    while (exp_cls_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk_gap = 0;
    out_ready = 1'b0;
    send(24'hA5C3E1, 1);
    wait_ov(40);
    ec = exp_cls_q[0];
    es = exp_score_q[0];
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      inp = 24'($urandom);
      @(negedge clk);
      chk("bp_cls", int'(out), ec);
      chk("bp_score", int'(out_score), es);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_in_ready_after", in_ready, 1);
    chk("bp_valid_after", out_valid, 0);
    chk("bp_hold_cls", int'(out), ec);

    // Reset in the middle of L0 aborts the vector
    send(24'h000000, 0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out", int'(out), 0);
    chk("abort_score", int'(out_score), 0);
    ov_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    chk("abort_no_valid", ov_seen, 0);
    send(24'h000000, 1);

    // Zero output layer: every class scores 0, tie goes to class 0
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      z_in_valid = 1'b1;
      z_inp = (v == 0) ? 24'hFFFFFF : 24'h123456;
      @(posedge clk);
      #1 z_in_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!z_out_valid && n < 60) begin
        @(negedge clk);
        n++;
      end
      chk("z_valid", z_out_valid, 1);
      chk("z_cls", int'(z_out), 0);
      chk("z_score", int'(z_out_score), 0);
    end

    n = 0;
    while (exp_cls_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drain", exp_cls_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
